// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state encodings, instruction length encodings and the opcode length decoder for fetch_sequencer
package fetch_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE       = 2'd0;
  localparam state_t S_FETCH_OP   = 2'd1;
  localparam state_t S_FETCH_OPND = 2'd2;
  localparam state_t S_ISSUE      = 2'd3;
  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;
  function automatic logic [1:0] decode_len(input logic [1:0] msbs);
    return msbs[1] ? LEN_3 : msbs[0] ? LEN_2 : LEN_1;
  endfunction
endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches 1..3 byte instructions at pc, steers the external PC via pc_en/pc_mode/pc_next, issues with valid/ready, honours redirects
//   clk, reset (async, active-high) | pc in | pc_en, pc_mode, pc_next out | mem_req out, mem_ready/mem_rdata in
//   instr_valid out, instr_ready in, instr_opcode/op1/op2/len/pc out | redirect, redirect_target in
//   optional FETCH_STALL_CNT_EN: stall_cnt[15:0] out, saturating count of memory-wait and issue back-pressure cycles
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_en,
  output logic             pc_mode,
  output logic [WIDTH-1:0] pc_next,
  output logic             mem_req,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr_opcode,
  output logic [WIDTH-1:0] instr_op1,
  output logic [WIDTH-1:0] instr_op2,
  output logic [1:0]       instr_len,
  output logic [WIDTH-1:0] instr_pc,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0]      stall_cnt,
`endif
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target
);
  state_t state, state_nx;
  logic opnd_idx;
  logic redir, accept, last_opnd;
  logic [1:0] new_len;
  // redirect outranks any byte arriving or instruction being accepted in the same cycle
  always_comb begin
    redir       = redirect && (state != S_IDLE);
    mem_req     = (state == S_FETCH_OP) || (state == S_FETCH_OPND);
    accept      = mem_req && mem_ready && !redir;
    pc_en       = accept || redir;
    pc_mode     = redir;
    pc_next     = redir ? redirect_target : '0;
    instr_valid = (state == S_ISSUE) && !redir;
    new_len     = decode_len(mem_rdata[WIDTH-1 -: 2]);
    last_opnd   = opnd_idx || (instr_len == LEN_2);
    state_nx    = redir                                  ? S_FETCH_OP :
                  (state == S_IDLE)                      ? S_FETCH_OP :
                  (state == S_FETCH_OP && accept)        ? ((new_len == LEN_1) ? S_ISSUE : S_FETCH_OPND) :
                  (state == S_FETCH_OPND && accept && last_opnd) ? S_ISSUE :
                  (state == S_ISSUE && instr_ready)      ? S_FETCH_OP : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      opnd_idx     <= 1'b0;
      instr_opcode <= '0;
      instr_op1    <= '0;
      instr_op2    <= '0;
      instr_len    <= 2'd0;
      instr_pc     <= '0;
    end else begin
      state <= state_nx;
      if (accept && state == S_FETCH_OP) begin
        instr_opcode <= mem_rdata;
        instr_pc     <= pc;
        instr_len    <= new_len;
        instr_op1    <= '0;
        instr_op2    <= '0;
        opnd_idx     <= 1'b0;
      end else if (accept) begin
        if (opnd_idx) instr_op2 <= mem_rdata;
        else instr_op1 <= mem_rdata;
        opnd_idx <= 1'b1;
      end
    end
  end
`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt <= 16'd0;
    else if (((mem_req && !mem_ready) || (instr_valid && !instr_ready)) && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 8, instruction-byte and address width.
REQ-002 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have ports: reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: pc  in  WIDTH  current program counter value; also used as the memory fetch address.
REQ-005 SHALL have ports: pc_en  out  1  program counter clock enable.
REQ-006 SHALL have ports: pc_mode  out  1  program counter mode (0=increment, 1=load pc_next).
REQ-007 SHALL have ports: pc_next  out  WIDTH  program counter load value.
REQ-008 SHALL have ports: mem_req  out  1  fetch request for byte at pc.
REQ-009 SHALL have ports: mem_ready  in  1  memory has returned mem_rdata this cycle.
REQ-010 SHALL have ports: mem_rdata  in  WIDTH  fetched byte.
REQ-011 SHALL have ports: instr_valid  out  1  assembled instruction available.
REQ-012 SHALL have ports: instr_ready  in  1  decode/execute accepts the instruction.
REQ-013 SHALL have ports: instr_opcode, instr_op1, instr_op2  out  WIDTH each  opcode and operand bytes.
REQ-014 SHALL have ports: instr_len  out  2  byte count of the instruction (1..3).
REQ-015 SHALL have ports: instr_pc  out  WIDTH  address of the opcode byte.
REQ-016 SHALL have ports: redirect  in  1  branch/jump taken.
REQ-017 SHALL have ports: redirect_target  in  WIDTH  new fetch address.

Function
REQ-018 SHALL implement an FSM with states IDLE, FETCH_OP, FETCH_OPND, ISSUE.
REQ-019 SHALL assert mem_req only in FETCH_OP and FETCH_OPND.
REQ-020 SHALL treat a byte as accepted on mem_req && mem_ready, which captures mem_rdata and drives pc_en=1, pc_mode=0 (PC increments) in that same cycle.
REQ-021 SHALL decode length from the opcode's two MSBs: 00 gives 1, 01 gives 2, 1x gives 3.
REQ-022 SHALL define FETCH_OP behaviour on accept as follows: latch instr_opcode and instr_pc=pc; go to ISSUE if the length is 1, else go to FETCH_OPND.
REQ-023 SHALL fill op1 and then op2 in FETCH_OPND, going to ISSUE once the last operand byte is accepted.
REQ-024 SHALL hold instr_valid=1 in ISSUE with stable outputs until instr_ready, then go to FETCH_OP on the next cycle.
REQ-025 SHALL achieve latency, with mem_ready tied high, of instr_valid asserting one cycle after the final byte accepted; throughput SHALL be one byte per cycle while fetching.
REQ-026 SHALL honour redirect in any non-IDLE state: pc_en=1, pc_mode=1, pc_next=redirect_target, discard the partial or pending instruction, instr_valid=0, next state FETCH_OP.
REQ-027 SHALL give redirect priority over a simultaneous mem_ready, discarding that byte, and over a simultaneous instr_ready, in which case the instruction is not delivered.
REQ-028 SHALL keep pc_en=0 whenever no accept or redirect occurs, so the PC holds.
REQ-029 SHALL zero unused operand outputs (instr_op2 for length 2; instr_op1 and instr_op2 for length 1).
REQ-030 SHALL wrap the PC modulo 2^WIDTH, with the sequencer treating address wrap as normal.

Reset
REQ-031 SHALL on reset enter IDLE with mem_req=0, pc_en=0, pc_mode=0, pc_next=0, instr_valid=0, all instr_* registers 0.
REQ-032 SHALL move IDLE to FETCH_OP one cycle after reset deasserts; IDLE SHALL ignore redirect.
REQ-033 SHALL abandon any in-flight fetch or issue when reset is asserted mid-operation, producing no pc_en pulse.

Configuration
REQ-034 SHALL provide macro FETCH_STALL_CNT_EN which, when defined, adds output stall_cnt [15:0] counting cycles with (mem_req && !mem_ready) or (instr_valid && !instr_ready), saturating at 16'hFFFF and cleared by reset.
REQ-035 SHALL omit the stall_cnt port and its logic when FETCH_STALL_CNT_EN is undefined, with all other behaviour identical.

Structure
REQ-036 SHALL place the state enum, the length-decode function and the instr_len encodings in package fetch_pkg.
REQ-037 SHALL instantiate no sub-modules, driving the program counter externally via pc_en/pc_mode/pc_next.

Verification
REQ-038 SHALL cover 1-byte instruction: pc=0x10, mem_rdata=0x05, mem_ready=1 -> one pc_en increment, instr_valid next cycle, opcode 0x05, len 1, instr_pc 0x10.
REQ-039 SHALL cover 3-byte instruction: bytes 0x80,0x11,0x22 with mem_ready=1 -> three increments, len 3, op1 0x11, op2 0x22.
REQ-040 SHALL cover memory stall: mem_ready low 4 cycles during op1 fetch -> pc_en=0 for those cycles, instruction unchanged when completed.
REQ-041 SHALL cover redirect with mem_ready in the same cycle in FETCH_OPND: target 0x40 -> pc_mode=1, pc_next=0x40, byte dropped, next mem_req at pc 0x40, no instr_valid.
REQ-042 SHALL cover back-pressure: instr_ready low 3 cycles in ISSUE -> outputs stable, no mem_req; with FETCH_STALL_CNT_EN stall_cnt increments by 3.
REQ-043 SHALL cover wrap: pc=0xFF with 2-byte opcode 0x40 -> op1 fetched at 0x00.
